dft_frame_sequencer: RTL and testbench
======================================

DFT_FRAME_SEQUENCER -- requirements
Module: dft_frame_sequencer

Interface
REQ-001 SHALL have parameter SPI_WIDTH, default 8: received byte width.
REQ-002 SHALL have parameter DFT_WIDTH, default 16: sample width and N width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: sample buffer depth, a power of 2.
REQ-004 SHALL have port i_sys_clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port i_sys_rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port i_ss, input, 1: SPI slave select, active low; low means a frame is open.
REQ-007 SHALL have port i_rx_data, input, SPI_WIDTH: received SPI byte, two's complement.
REQ-008 SHALL have port i_rx_ready, input, 1: one-cycle strobe; i_rx_data is valid in that cycle.
REQ-009 SHALL have port i_N, input, DFT_WIDTH: number of samples per frame, unsigned.
REQ-010 SHALL have port o_x, output, DFT_WIDTH: signed sample to the DFT core.
REQ-011 SHALL have port o_x_valid, output, 1: o_x is valid.
REQ-012 SHALL have port i_x_ready, input, 1: DFT core accepts o_x.
REQ-013 SHALL have port o_dft_start, output, 1: one-cycle pulse at frame start.
REQ-014 SHALL have port i_dft_done, input, 1: DFT core results are final (level).
REQ-015 SHALL have port o_done, output, 1: one-cycle frame-complete pulse.
REQ-016 SHALL have port o_abort, output, 1: one-cycle frame-aborted pulse.
REQ-017 SHALL have port o_busy, output, 1: high in every state except IDLE.
REQ-018 SHALL have port o_overflow, output, 1: sticky flag; a byte was dropped because the FIFO was full.

Function
REQ-019 SHALL implement the states IDLE, RUN, WAIT_DONE and HOLD.
REQ-020 IDLE: when i_ss==0 and i_N!=0, latch i_N into n_reg, clear the counters, pulse o_dft_start and go to RUN.
REQ-021 IDLE: when i_N==0, remain in IDLE with no pulse.
REQ-022 RUN: each i_rx_ready with accept_cnt<n_reg SHALL push sign_extend(i_rx_data) to DFT_WIDTH and increment accept_cnt.
REQ-023 RUN: a byte arriving while the FIFO is full and no pop occurs in that cycle SHALL be dropped, SHALL set o_overflow, and SHALL NOT increment accept_cnt.
REQ-024 A push and a pop in the same cycle while full SHALL both succeed.
REQ-025 Bytes arriving with accept_cnt==n_reg SHALL be discarded silently, without setting o_overflow.
REQ-026 o_x SHALL be the FIFO head and o_x_valid SHALL equal FIFO not-empty.
REQ-027 A pop SHALL occur when o_x_valid and i_x_ready are both high; each pop increments issue_cnt.
REQ-028 Latency: i_rx_ready at cycle t into an empty FIFO SHALL give o_x_valid=1 at t+1.
REQ-029 RUN: when a pop makes issue_cnt==n_reg, go to WAIT_DONE in the next cycle.
REQ-030 RUN: when i_ss==1 while issue_cnt<n_reg, flush the FIFO, pulse o_abort and go to IDLE.
REQ-031 Abort (REQ-030) SHALL take priority over a push in the same cycle.
REQ-032 WAIT_DONE: on i_dft_done==1, pulse o_done and go to HOLD; i_ss is ignored in this state.
REQ-033 HOLD: remain until i_ss==1, then go to IDLE, so that each frame requires a new i_ss assertion.
REQ-034 Counters SHALL be DFT_WIDTH bits wide; n_reg==2^DFT_WIDTH-1 SHALL be supported without wrap.
REQ-035 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with one extra pointer bit used for full/empty detection.
REQ-036 o_overflow SHALL clear only on reset or on a frame start (REQ-020).

Reset
REQ-037 i_sys_rst==1 SHALL on the next edge force state IDLE, empty the FIFO, and clear n_reg, accept_cnt, issue_cnt and o_overflow.
REQ-038 After reset, o_x, o_x_valid, o_dft_start, o_done, o_abort and o_busy SHALL all be 0.
REQ-039 Reset SHALL override all other events, including mid-frame; no o_abort or o_done pulse SHALL be produced.

Verification
REQ-040 Nominal: N=2, i_x_ready=1, bytes {0x01,0xFC,0x01,0x01} -> o_x=0x0001 then 0xFFFC, byte 3/4 dropped, o_overflow=0, o_done one cycle after i_dft_done.
REQ-041 Overflow: N=8, i_x_ready=0, 5 bytes 0x10..0x14 -> FIFO holds 0x0010..0x0013, o_overflow=1; releasing i_x_ready issues those 4 in order.
REQ-042 Abort: N=4, 2 bytes sent, then i_ss=1 -> o_abort pulse, o_x_valid=0 next cycle, state IDLE, no o_done.
REQ-043 Full push/pop: FIFO full, i_x_ready=1 coincident with i_rx_ready -> count stays FIFO_DEPTH, o_overflow stays 0.
REQ-044 N=0 with i_ss=0 -> no o_dft_start and o_busy=0; reset asserted mid-RUN -> all outputs 0 at the next cycle.

Source files
------------

// File: rtl/dft_frame_sequencer.sv
// Frame sequencer between an SPI byte receiver and a DFT core: it buffers sign-extended
// samples in a small FIFO, counts accepted and issued samples, and handles done/abort handshakes.
module dft_frame_sequencer #(
    parameter int SPI_WIDTH  = 8,
    parameter int DFT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_sys_clk,
    input  logic                 i_sys_rst,
    input  logic                 i_ss,
    input  logic [SPI_WIDTH-1:0] i_rx_data,
    input  logic                 i_rx_ready,
    input  logic [DFT_WIDTH-1:0] i_N,
    output logic [DFT_WIDTH-1:0] o_x,
    output logic                 o_x_valid,
    input  logic                 i_x_ready,
    output logic                 o_dft_start,
    input  logic                 i_dft_done,
    output logic                 o_done,
    output logic                 o_abort,
    output logic                 o_busy,
    output logic                 o_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, WAIT_DONE, HOLD} state_t;

    state_t state, state_nxt;

    logic [DFT_WIDTH-1:0]        n_reg;
    logic [DFT_WIDTH-1:0]        accept_cnt;
    logic [DFT_WIDTH-1:0]        issue_cnt;
    logic signed [DFT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]              wr_ptr;
    logic [PTR_W:0]              rd_ptr;

    logic empty, full, pop, push, drop;
    logic start, abort, finish, last_pop, byte_wanted;

    function automatic logic signed [DFT_WIDTH-1:0] sign_extend(input logic [SPI_WIDTH-1:0] b);
        logic signed [SPI_WIDTH-1:0] s;
        s = b;
        return DFT_WIDTH'(s);
    endfunction

    // Extra pointer bit distinguishes full (MSBs differ) from empty (pointers equal).
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop       = !empty && i_x_ready;
    assign o_x_valid = !empty;
    assign o_x       = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

    // State register; the handshake pulses are registered alongside it.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state       <= IDLE;
            o_dft_start <= 1'b0;
            o_done      <= 1'b0;
            o_abort     <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_dft_start <= start;
            o_done      <= finish;
            o_abort     <= abort;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (start) state_nxt = RUN;
            RUN: begin
                if (abort)         state_nxt = IDLE;
                else if (last_pop) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: if (i_dft_done) state_nxt = HOLD;
            HOLD:      if (i_ss) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Abort wins over a push; a full FIFO still accepts a byte when a pop frees a slot.
    always_comb begin
        start       = (state == IDLE) && !i_ss && (i_N != '0);
        abort       = (state == RUN) && i_ss && (issue_cnt < n_reg);
        finish      = (state == WAIT_DONE) && i_dft_done;
        last_pop    = (state == RUN) && pop && ((issue_cnt + DFT_WIDTH'(1)) == n_reg);
        byte_wanted = (state == RUN) && i_rx_ready && (accept_cnt < n_reg) && !abort;
        push        = byte_wanted && (!full || pop);
        drop        = byte_wanted && full && !pop;
        o_busy      = (state != IDLE);
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            n_reg      <= '0;
            accept_cnt <= '0;
            issue_cnt  <= '0;
            o_overflow <= 1'b0;
        end else if (start) begin
            n_reg      <= i_N;
            accept_cnt <= '0;
            issue_cnt  <= '0;
            o_overflow <= 1'b0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + (PTR_W+1)'(1);
                accept_cnt <= accept_cnt + DFT_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + (PTR_W+1)'(1);
                issue_cnt <= issue_cnt + DFT_WIDTH'(1);
            end
            if (drop) o_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= sign_extend(i_rx_data);
    end

endmodule

// File: tb/tb_dft_frame_sequencer.sv
// Bench for dft_frame_sequencer: a queue-based frame model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dft_frame_sequencer;

    localparam int SW = 8;
    localparam int DW = 16;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          ss;
    logic [SW-1:0] rx_data;
    logic          rx_ready;
    logic [DW-1:0] n_in;
    logic [DW-1:0] x;
    logic          x_valid;
    logic          x_ready;
    logic          dft_start;
    logic          dft_done;
    logic          done;
    logic          abort;
    logic          busy;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    dft_frame_sequencer #(.SPI_WIDTH(SW), .DFT_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .i_sys_clk  (clk),
        .i_sys_rst  (rst),
        .i_ss       (ss),
        .i_rx_data  (rx_data),
        .i_rx_ready (rx_ready),
        .i_N        (n_in),
        .o_x        (x),
        .o_x_valid  (x_valid),
        .i_x_ready  (x_ready),
        .o_dft_start(dft_start),
        .i_dft_done (dft_done),
        .o_done     (done),
        .o_abort    (abort),
        .o_busy     (busy),
        .o_overflow (overflow)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Frame model: phase 0 idle, 1 collecting/issuing, 2 awaiting done, 3 holding for ss release.
    logic [DW-1:0] mq[$];
    int            m_phase = 0;
    int            m_n = 0;
    int            m_acc = 0;
    int            m_iss = 0;
    bit            m_ovf = 0;
    bit            m_start = 0;
    bit            m_done = 0;
    bit            m_abort = 0;

    function automatic logic [DW-1:0] widen(input logic [SW-1:0] b);
        int v;
        v = int'(b);
        if (v >= 128) v = v - 256;
        return v[DW-1:0];
    endfunction

    initial begin
        bit popped;
        forever begin
            @(posedge clk);
            m_start = 0;
            m_done  = 0;
            m_abort = 0;
            if (rst) begin
                mq.delete();
                m_phase = 0; m_n = 0; m_acc = 0; m_iss = 0; m_ovf = 0;
            end else begin
                case (m_phase)
                    0: if (!ss && n_in != 0) begin
                        m_n = int'(n_in); m_acc = 0; m_iss = 0; m_ovf = 0;
                        m_start = 1; m_phase = 1;
                    end
                    1: begin
                        popped = (mq.size() > 0) && x_ready;
                        if (ss) begin
                            mq.delete();
                            m_abort = 1;
                            m_phase = 0;
                        end else begin
                            if (popped) begin
                                void'(mq.pop_front());
                                m_iss++;
                            end
                            if (rx_ready && m_acc < m_n) begin
                                if (mq.size() < DEPTH) begin
                                    mq.push_back(widen(rx_data));
                                    m_acc++;
                                end else begin
                                    m_ovf = 1;
                                end
                            end
                            if (popped && m_iss == m_n) m_phase = 2;
                        end
                    end
                    2: if (dft_done) begin
                        m_done = 1; m_phase = 3;
                    end
                    default: if (ss) m_phase = 0;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [DW-1:0] exp_x;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_x = (mq.size() > 0) ? mq[0] : '0;
                chk("model_x_valid", 32'(x_valid), 32'(mq.size() > 0));
                chk("model_x", 32'(x), 32'(exp_x));
                chk("model_busy", 32'(busy), 32'(m_phase != 0));
                chk("model_overflow", 32'(overflow), 32'(m_ovf));
                chk("model_dft_start", 32'(dft_start), 32'(m_start));
                chk("model_done", 32'(done), 32'(m_done));
                chk("model_abort", 32'(abort), 32'(m_abort));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [SW-1:0] b);
        rx_ready = 1; rx_data = b;
        tick();
        rx_ready = 0;
    endtask

    initial begin
        int nv;
        bit ss_lvl;
        rst = 1; ss = 1; rx_data = '0; rx_ready = 0; n_in = '0; x_ready = 0; dft_done = 0;
        tick(); tick();
        chk_en = 1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_x_valid", 32'(x_valid), 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_pulses", {29'd0, dft_start, done, abort}, 0);
        chk("rst_overflow", 32'(overflow), 0);
        rst = 0;
        tick();

        // Nominal: N=2, bytes 01 FC 01 01
        ss = 0; n_in = 16'd2; x_ready = 1;
        tick();
        chk("nom_start", 32'(dft_start), 1);
        chk("nom_busy", 32'(busy), 1);
        rx_ready = 1; rx_data = 8'h01; tick();
        chk("nom_first_valid", 32'(x_valid), 1);
        chk("nom_first_x", 32'(x), 32'h0001);
        rx_data = 8'hFC; tick();
        chk("nom_second_x", 32'(x), 32'hFFFC);
        rx_data = 8'h01; tick();
        chk("nom_drained", 32'(x_valid), 0);
        rx_data = 8'h01; tick();
        rx_ready = 0;
        chk("nom_no_overflow", 32'(overflow), 0);
        chk("nom_still_valid0", 32'(x_valid), 0);
        dft_done = 1; tick();
        dft_done = 0;
        chk("nom_done_pulse", 32'(done), 1);
        tick();
        chk("nom_done_clear", 32'(done), 0);
        ss = 1; tick(); tick();
        chk("nom_idle", 32'(busy), 0);

        // Overflow: N=8, sink stalled, 5 bytes
        ss = 0; n_in = 16'd8; x_ready = 0;
        tick();
        for (int i = 0; i < 5; i++) send(8'(8'h10 + i));
        chk("ovf_flag", 32'(overflow), 1);
        x_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_order", 32'(x), 32'(16'h0010 + i));
            tick();
        end
        chk("ovf_empty", 32'(x_valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        x_ready = 0; ss = 1; tick();
        chk("ovf_abort", 32'(abort), 1);
        tick();

        // Abort after 2 of 4
        ss = 0; n_in = 16'd4; tick();
        chk("abt_start_clears_ovf", 32'(overflow), 0);
        send(8'h55); send(8'hAA);
        ss = 1; tick();
        chk("abt_pulse", 32'(abort), 1);
        chk("abt_flushed", 32'(x_valid), 0);
        chk("abt_idle", 32'(busy), 0);
        tick();
        chk("abt_pulse_end", 32'(abort), 0);
        chk("abt_no_done", 32'(done), 0);

        // Full FIFO with coincident push and pop
        ss = 0; n_in = 16'd8; tick();
        for (int i = 0; i < 4; i++) send(8'(8'h20 + i));
        rx_ready = 1; rx_data = 8'h24; x_ready = 1; tick();
        rx_ready = 0;
        chk("full_pp_overflow", 32'(overflow), 0);
        chk("full_pp_head", 32'(x), 32'h0021);
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            if (x_valid) nv++;
            tick();
        end
        chk("full_pp_count", 32'(nv), 32'(DEPTH));
        x_ready = 0; ss = 1; tick(); tick();

        // N=0 never starts
        ss = 0; n_in = '0; tick(); tick();
        chk("n0_no_start", 32'(dft_start), 0);
        chk("n0_not_busy", 32'(busy), 0);

        // Reset in the middle of a frame
        n_in = 16'd5; tick();
        send(8'h01); send(8'h02);
        rst = 1; tick();
        chk("mid_rst_outputs", {26'd0, x_valid, dft_start, done, abort, busy, overflow}, 0);
        chk("mid_rst_x", 32'(x), 0);
        rst = 0; ss = 1; tick();

        // Randomized traffic against the model
        ss_lvl = 1;
        for (int c = 0; c < 6000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 29) == 0) ss_lvl = ~ss_lvl;
            ss = ss_lvl;
            case ($urandom_range(0, 9))
                0:       n_in = '0;
                1:       n_in = 16'hFFFF;
                default: n_in = 16'($urandom_range(1, 7));
            endcase
            rx_ready = ($urandom_range(0, 1) == 1);
            rx_data  = 8'($urandom_range(0, 255));
            x_ready  = ($urandom_range(0, 3) != 0);
            dft_done = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst = 0; rx_ready = 0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
